// File: rtl/mem_block_fill.sv
// Backing main-memory stage for the data cache: accepts a block address on a miss,
// waits a fixed latency, streams the block one word per clock, then pulses done.
module mem_block_fill #(
    parameter int WORD     = 32,
    parameter int ADDRESSL = 15,
    parameter int OFFSETL  = 2,
    parameter int LATENCY  = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req,
    input  logic [ADDRESSL-OFFSETL-1:0]  blkAdr,
    output logic                         busy,
    output logic                         wordValid,
    output logic [OFFSETL-1:0]           wordIndex,
    output logic [WORD-1:0]              dataOut,
    output logic                         done,
    output logic [ADDRESSL-1:0]          fillCount
);

    localparam int BLKL = ADDRESSL - OFFSETL;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] BURST = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [3:0]         CNT_INIT = 4'(LATENCY - 1);
    localparam logic [OFFSETL-1:0] LAST_IDX = '1;

    logic [1:0]         state;
    logic [3:0]         cnt;
    logic [BLKL-1:0]    adr;
    logic [OFFSETL-1:0] idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            adr       <= '0;
            idx       <= '0;
            busy      <= 1'b0;
            wordValid <= 1'b0;
            wordIndex <= '0;
            dataOut   <= '0;
            done      <= 1'b0;
            fillCount <= '0;
        end else begin
            wordValid <= 1'b0;
            wordIndex <= '0;
            dataOut   <= '0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        adr   <= blkAdr;
                        cnt   <= CNT_INIT;
                        busy  <= 1'b1;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        idx   <= '0;
                        state <= BURST;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                BURST: begin
                    // Memory holds mem[i] = i and is never written, so the read is the
                    // zero-extended word address; the offset wraps inside the block.
                    wordValid <= 1'b1;
                    wordIndex <= idx;
                    dataOut   <= WORD'({adr, idx});
                    idx       <= idx + 1'b1;
                    if (idx == LAST_IDX) state <= DONE;
                end
                DONE: begin
                    // Outputs lag state by one edge: the done pulse cycle runs with the
                    // FSM already back in IDLE, so a req sampled then starts a new fill.
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    fillCount <= fillCount + 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_block_fill.sv
// Self-checking bench for mem_block_fill: directed scenarios plus random traffic,
// all compared cycle by cycle against a fill-timeline reference model.
module tb_mem_block_fill;

    localparam int W  = 32;
    localparam int AL = 15;
    localparam int OL = 2;
    localparam int L  = 3;
    localparam int B  = 1 << OL;
    localparam int VW = 2 + OL + W + 1 + AL;

    logic              clk;
    logic              rst;
    logic              req;
    logic [AL-OL-1:0]  blkAdr;
    logic              busy;
    logic              wordValid;
    logic [OL-1:0]     wordIndex;
    logic [W-1:0]      dataOut;
    logic              done;
    logic [AL-1:0]     fillCount;

    int n_chk = 0;
    int n_fail = 0;

    mem_block_fill #(
        .WORD(W),
        .ADDRESSL(AL),
        .OFFSETL(OL),
        .LATENCY(L)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .blkAdr(blkAdr),
        .busy(busy),
        .wordValid(wordValid),
        .wordIndex(wordIndex),
        .dataOut(dataOut),
        .done(done),
        .fillCount(fillCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a fill is a timeline k = edges since acceptance.
    // busy for k in 0..L+B, word (k-L-1) for k in L+1..L+B, done at k = L+B+1.
    bit    m_act = 1'b0;
    int    m_k = 0;
    int    m_adr = 0;
    int    m_fills = 0;
    logic  m_busy, e_wv, e_done;
    logic [OL-1:0] e_idx, d_idx;
    logic [W-1:0]  e_data;
    logic [VW-1:0] exp_vec, dut_vec;

    always_comb begin
        m_busy = m_act && (m_k <= L + B);
        e_wv   = m_act && (m_k >= L + 1) && (m_k <= L + B);
        e_done = m_act && (m_k == L + B + 1);
        e_idx  = '0;
        e_data = '0;
        if (e_wv) begin
            e_idx  = OL'(m_k - L - 1);
            e_data = W'(m_adr * B + (m_k - L - 1));
        end
        exp_vec = {m_busy, e_wv, e_idx, e_data, e_done, AL'(m_fills)};
        d_idx   = wordValid ? wordIndex : '0;
        dut_vec = {busy, wordValid, d_idx, dataOut, done, fillCount};
    end

    always @(posedge clk) begin
        if (rst) begin
            m_act   <= 1'b0;
            m_k     <= 0;
            m_fills <= 0;
        end else if (!m_busy && req) begin
            m_act <= 1'b1;
            m_k   <= 0;
            m_adr <= int'(blkAdr);
        end else if (m_act) begin
            if (m_k == L + B + 1) m_act <= 1'b0;
            else                  m_k <= m_k + 1;
            if (m_k == L + B) m_fills <= (m_fills + 1) % (1 << AL);
        end
    end

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; blkAdr = '0;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({busy, wordValid, wordIndex, dataOut, done, fillCount} !== '0) begin
            n_fail++;
            $display("FAIL reset_values got=%h exp=0", {busy, wordValid, wordIndex, dataOut, done, fillCount});
        end
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (dut_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL reset_idle got=%h exp=%h", dut_vec, exp_vec);
        end
    endtask

    task automatic test_basic();
        int first_v = -1;
        int done_c = -1;
        req = 1'b1; blkAdr = 13'd256;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 0) req = 1'b0;
            n_chk++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL basic_cycle c=%0d got=%h exp=%h", c, dut_vec, exp_vec);
            end
            if (wordValid && first_v < 0) begin
                first_v = c;
                n_chk++;
                if (dataOut !== 32'd1024) begin
                    n_fail++;
                    $display("FAIL basic_first_word got=%0d exp=1024", dataOut);
                end
            end
            if (done && done_c < 0) done_c = c;
        end
        n_chk++;
        if (first_v !== 4) begin
            n_fail++;
            $display("FAIL basic_first_valid_cycle got=%0d exp=4", first_v);
        end
        n_chk++;
        if (done_c !== 8) begin
            n_fail++;
            $display("FAIL basic_done_cycle got=%0d exp=8", done_c);
        end
        n_chk++;
        if (fillCount !== 15'd1) begin
            n_fail++;
            $display("FAIL basic_fillcount got=%0d exp=1", fillCount);
        end
    endtask

    task automatic test_back_to_back();
        int words[$];
        int n_done = 0;
        int second_first = -1;
        int expw[8] = '{1024, 1025, 1026, 1027, 1200, 1201, 1202, 1203};
        req = 1'b1; blkAdr = 13'd256;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            if (c == 5) blkAdr = 13'd300;
            if (c == 9) req = 1'b0;
            n_chk++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL b2b_cycle c=%0d got=%h exp=%h", c, dut_vec, exp_vec);
            end
            if (wordValid) begin
                if (words.size() == 4) second_first = c;
                words.push_back(int'(dataOut));
            end
            if (done) n_done++;
        end
        n_chk++;
        if (words.size() != 8) begin
            n_fail++;
            $display("FAIL b2b_word_count got=%0d exp=8", words.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_chk++;
                if (words[i] != expw[i]) begin
                    n_fail++;
                    $display("FAIL b2b_word i=%0d got=%0d exp=%0d", i, words[i], expw[i]);
                end
            end
        end
        n_chk++;
        if (n_done != 2 || second_first != 13) begin
            n_fail++;
            $display("FAIL b2b_spacing got done=%0d first2=%0d exp done=2 first2=13", n_done, second_first);
        end
    endtask

    task automatic test_top_block();
        int n_done = 0;
        int last_w = -1;
        req = 1'b1; blkAdr = 13'd8191;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 0) req = 1'b0;
            n_chk++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL top_cycle c=%0d got=%h exp=%h", c, dut_vec, exp_vec);
            end
            if (wordValid) last_w = int'(dataOut);
            if (done) n_done++;
        end
        n_chk++;
        if (last_w != 32767 || n_done != 1) begin
            n_fail++;
            $display("FAIL top_block got last=%0d done=%0d exp last=32767 done=1", last_w, n_done);
        end
    endtask

    task automatic test_reset_mid_burst();
        int n_done = 0;
        req = 1'b1; blkAdr = 13'd500;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (c == 0) req = 1'b0;
            if (c == 6) begin
                n_chk++;
                if ({busy, wordValid, wordIndex, dataOut, done, fillCount} !== '0) begin
                    n_fail++;
                    $display("FAIL midrst_zero got=%h exp=0", {busy, wordValid, wordIndex, dataOut, done, fillCount});
                end
                rst = 1'b0;
            end
            if (c == 5) rst = 1'b1;
            n_chk++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL midrst_cycle c=%0d got=%h exp=%h", c, dut_vec, exp_vec);
            end
            if (done) n_done++;
        end
        n_chk++;
        if (n_done != 0 || fillCount !== '0) begin
            n_fail++;
            $display("FAIL midrst_abandon got done=%0d fills=%0d exp done=0 fills=0", n_done, fillCount);
        end
        req = 1'b1; blkAdr = 13'd7;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 0) req = 1'b0;
            n_chk++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL midrst_refill c=%0d got=%h exp=%h", c, dut_vec, exp_vec);
            end
        end
        n_chk++;
        if (fillCount !== 15'd1) begin
            n_fail++;
            $display("FAIL midrst_refill_count got=%0d exp=1", fillCount);
        end
    endtask

    task automatic test_rst_with_req();
        int n_valid = 0;
        rst = 1'b1; req = 1'b1; blkAdr = 13'd42;
        @(negedge clk);
        rst = 1'b0; req = 1'b0;
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstreq_busy got=%b exp=0", busy);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_chk++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL rstreq_cycle c=%0d got=%h exp=%h", c, dut_vec, exp_vec);
            end
            if (wordValid) n_valid++;
        end
        n_chk++;
        if (n_valid != 0) begin
            n_fail++;
            $display("FAIL rstreq_words got=%0d exp=0", n_valid);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            rst    = ($urandom_range(0, 63) == 0);
            req    = ($urandom_range(0, 2) == 0);
            blkAdr = 13'($urandom);
            @(negedge clk);
            n_chk++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL random_cycle c=%0d got=%h exp=%h", c, dut_vec, exp_vec);
            end
        end
        rst = 1'b0; req = 1'b0;
    endtask

    task automatic test_sequential_fills();
        int k = 0;
        int budget = 0;
        rst = 1'b1; req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        req = 1'b1; blkAdr = 13'd256;
        while (k < 8192 && budget < 8192 * (L + B + 2) + 50) begin
            @(negedge clk);
            budget++;
            n_chk++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL seq_cycle k=%0d got=%h exp=%h", k, dut_vec, exp_vec);
            end
            if (e_done) begin
                k++;
                if (k == 8192) req = 1'b0;
                else           blkAdr = 13'(256 + k);
            end
        end
        n_chk++;
        if (k != 8192) begin
            n_fail++;
            $display("FAIL seq_timeout got=%0d fills exp=8192", k);
        end
        n_chk++;
        if (fillCount !== 15'd8192) begin
            n_fail++;
            $display("FAIL seq_fillcount got=%0d exp=8192", fillCount);
        end
        req = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; blkAdr = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_top_block();
        test_reset_mid_burst();
        test_rst_with_req();
        test_random();
        test_sequential_fills();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_block_fill.md
Name: mem_block_fill

Overview:
- Backing main-memory stage directly downstream of the direct-mapped data cache.
- On a cache miss it accepts a block address and waits a fixed access latency.
- It then streams the block's words one per clock to the cache's refill path and pulses done.
- It also counts completed fills so the bench can cross-check the cache's miss count against numOfHits.

Parameters:
- WORD, 32, data word width in bits.
- ADDRESSL, 15, word-address width (memory depth 2**ADDRESSL words).
- OFFSETL, 2, block-offset width; words per block BLOCK_WORDS = 2**OFFSETL.
- LATENCY, 3, wait cycles between accept and first word; legal range 1..15.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- req  input  1  fill request; sampled on posedge.
- blkAdr  input  ADDRESSL-OFFSETL  block address; word address = {blkAdr, index}.
- busy  output  1  high while a fill is in progress.
- wordValid  output  1  dataOut/wordIndex carry a valid block word this cycle.
- wordIndex  output  OFFSETL  offset of the current word within the block.
- dataOut  output  WORD  memory word read at {latched blkAdr, wordIndex}.
- done  output  1  one-cycle pulse after the last word of a fill.
- fillCount  output  ADDRESSL  number of completed fills, wraps modulo 2**ADDRESSL.

Behaviour:
- Memory: array of 2**ADDRESSL words, read-only from this port.
  - Initialized at time zero to mem[i] = i, zero-extended to WORD.
  - Not affected by rst.
- All outputs are registered.
- Reset values: busy=0, wordValid=0, wordIndex=0, dataOut=0, done=0, fillCount=0; FSM in IDLE.
- FSM states: IDLE, WAIT, BURST, DONE.
- IDLE (busy=0):
  - req=1 at edge E0 latches blkAdr, loads the wait counter with LATENCY-1, and moves to WAIT.
  - busy=1 from after E0.
- WAIT:
  - The counter decrements each edge.
  - At the edge where counter==0, move to BURST with index=0.
- BURST:
  - Each cycle: wordValid=1, wordIndex=index, dataOut=mem[{latched blkAdr, index}].
  - index increments each edge.
  - After the word with index=BLOCK_WORDS-1, move to DONE.
- Word timing: words are valid in the cycles following edges E0+LATENCY+1 through E0+LATENCY+BLOCK_WORDS, with ascending wordIndex and no gaps.
- DONE (one cycle, after edge E0+LATENCY+BLOCK_WORDS+1):
  - done=1, busy=0, wordValid=0, dataOut=0.
  - fillCount increments by 1 on entry.
- Request acceptance:
  - req is accepted whenever busy=0 at the sampling edge, i.e. in IDLE or DONE.
  - A req sampled at the edge ending DONE starts a new fill (back-to-back fills, one-cycle gap).
  - From DONE without req, return to IDLE.
- Changes on blkAdr or req while busy=1 are ignored; the latched address is used for the whole burst.
- Outside BURST, wordValid=0 and dataOut=0.
- Index arithmetic stays within the block: {blkAdr, index} never carries into blkAdr. blkAdr = max reads the top BLOCK_WORDS words.
- rst=1 at any edge (including mid-WAIT or mid-BURST):
  - Forces the reset values on the next cycle.
  - Any partial fill is abandoned: no done, no fillCount increment.
- rst and req high at the same edge: reset wins; the request is dropped.
- fillCount wraps from 2**ADDRESSL-1 to 0.

Test Plan:
1. rst, then req=1 for one cycle with blkAdr=256 (LATENCY=3) -> busy high; wordValid in cycles 4..7 after accept with wordIndex 0..3 and dataOut 1024,1025,1026,1027; done=1 in cycle 8 with busy=0; fillCount=1.
2. req held at 1 continuously, blkAdr changed mid-burst from 256 to 300 -> first burst returns 1024..1027 unchanged; second fill accepted at the edge ending DONE and returns 1200..1203; exactly one idle (done) cycle between bursts.
3. blkAdr=8191 -> dataOut 32764,32765,32766,32767; no address wrap; done pulses once.
4. rst=1 for one cycle after the 2nd BURST word -> next cycle all outputs 0; no done; fillCount=0; a new req then fills normally.
5. rst=1 and req=1 on the same edge -> FSM stays IDLE, busy=0, no words emitted.
6. 8192 sequential fills with blkAdr=256+k (k=0..8191), checking each word equals its address -> fillCount ends at 8192; no dataOut mismatch.
